// File: rtl/cobs_frame_decoder.sv
// COBS frame decoder: strips 0x00 delimiters, restores substituted zeros and emits AXI-Stream payload bytes with tlast/tuser.
// Optional statistics counters are built only when COBS_FRAME_DECODER_STATS_EN is defined.
module cobs_frame_decoder #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic                   decode_error,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [COUNT_WIDTH-1:0] error_count
);

  typedef enum logic {
    WAIT_CODE = 1'b0,
    DATA      = 1'b1
  } state_t;

  state_t     r_state;
  logic       r_run;
  logic [7:0] r_hold_data;
  logic       r_hold_valid;
  logic [7:0] r_remaining;
  logic       r_pending_zero;
  logic       r_is_ff;
  logic       r_in_frame;
  logic [7:0] r_m_tdata;
  logic       r_m_tvalid;
  logic       r_m_tlast;
  logic       r_m_tuser;
  logic       r_decode_error;

  logic       w_accept;
  logic       w_push;
  logic [7:0] w_push_data;
  logic       w_eof;
  logic       w_err;
  logic       w_end;

  // r_run keeps the input closed while reset is held and for the first edge after it.
  assign s_axis_tready = r_run && (!r_m_tvalid || m_axis_tready);
  assign w_accept      = s_axis_tvalid && s_axis_tready;

  // NOTE: every output of an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_push      = 1'b0;
    w_push_data = s_axis_tdata;
    w_eof       = 1'b0;
    w_err       = 1'b0;
    if (w_accept) begin
      case (r_state)
        WAIT_CODE: begin
          if (s_axis_tdata == 8'h00) begin
            w_eof = r_in_frame;
          end else if (r_pending_zero) begin
            w_push      = 1'b1;
            w_push_data = 8'h00;
          end
        end
        DATA: begin
          if (s_axis_tdata != 8'h00) w_push = 1'b1;
          else                       w_err  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_end = w_eof || w_err;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the hold byte is reset too; it is a single register, not a memory, so this is cheap and keeps outputs deterministic.
      r_state        <= WAIT_CODE;
      r_run          <= 1'b0;
      r_hold_data    <= 8'h00;
      r_hold_valid   <= 1'b0;
      r_remaining    <= 8'h00;
      r_pending_zero <= 1'b0;
      r_is_ff        <= 1'b0;
      r_in_frame     <= 1'b0;
      r_m_tdata      <= 8'h00;
      r_m_tvalid     <= 1'b0;
      r_m_tlast      <= 1'b0;
      r_m_tuser      <= 1'b0;
      r_decode_error <= 1'b0;
    end else begin
      r_run          <= 1'b1;
      r_decode_error <= w_err;

      // The output register is free whenever a byte is accepted, so it is never overwritten while stalled.
      if (w_push && r_hold_valid) begin
        r_m_tdata  <= r_hold_data;
        r_m_tlast  <= 1'b0;
        r_m_tuser  <= 1'b0;
        r_m_tvalid <= 1'b1;
      end else if (w_end && r_hold_valid) begin
        r_m_tdata  <= r_hold_data;
        r_m_tlast  <= 1'b1;
        r_m_tuser  <= w_err;
        r_m_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end

      if (w_push) begin
        r_hold_data  <= w_push_data;
        r_hold_valid <= 1'b1;
      end else if (w_end) begin
        r_hold_valid <= 1'b0;
      end

      if (w_accept) begin
        case (r_state)
          WAIT_CODE: begin
            if (s_axis_tdata != 8'h00) begin
              r_in_frame  <= 1'b1;
              r_remaining <= s_axis_tdata - 8'd1;
              r_is_ff     <= (s_axis_tdata == 8'hFF);
              if (s_axis_tdata > 8'd1) begin
                r_state        <= DATA;
                r_pending_zero <= 1'b0;
              end else begin
                r_pending_zero <= 1'b1;
              end
            end else if (r_in_frame) begin
              // The implicit zero of the last group is the frame's trailing zero and is dropped.
              r_pending_zero <= 1'b0;
              r_in_frame     <= 1'b0;
            end
          end
          DATA: begin
            if (s_axis_tdata != 8'h00) begin
              r_remaining <= r_remaining - 8'd1;
              if (r_remaining == 8'd1) begin
                r_state        <= WAIT_CODE;
                r_pending_zero <= !r_is_ff;
              end
            end else begin
              r_state        <= WAIT_CODE;
              r_pending_zero <= 1'b0;
              r_in_frame     <= 1'b0;
            end
          end
          default: r_state <= WAIT_CODE;
        endcase
      end
    end
  end

  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tuser  = r_m_tuser;
  assign decode_error  = r_decode_error;

`ifdef COBS_FRAME_DECODER_STATS_EN
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  logic [COUNT_WIDTH-1:0] r_frame_count;
  logic [COUNT_WIDTH-1:0] r_error_count;

  // Truncated frames still terminate a frame, so they count in both statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_count <= '0;
      r_error_count <= '0;
    end else begin
      if (w_end && (r_frame_count != '1)) r_frame_count <= r_frame_count + CNT_ONE;
      if (w_err && (r_error_count != '1)) r_error_count <= r_error_count + CNT_ONE;
    end
  end

  assign frame_count = r_frame_count;
  assign error_count = r_error_count;
`else
  assign frame_count = '0;
  assign error_count = '0;
`endif

endmodule
